// File: rtl/mii_io_tx.sv
// mii_io_tx -- PHY-side MII transmit pin interface.
//
// Generates TX_CLK toward the MAC from the on-chip clk/ce period enable. It samples
// TX_EN/TX_ER/TXD once per MII period, on the cycle just before TX_CLK rises, and
// presents the nibble on-chip with a one-cycle strobe. It also provides jabber
// protection and an isolate mode that tri-states TX_CLK. The block sits between the
// MII TX pins and the PCS transmit path.
//
// Ports:
//   clk      in   system clock, all logic on posedge
//   rst      in   synchronous active-high reset
//   isolate  in   1 = tx_clk high-Z, pin inputs ignored
//   ce       in   MII period enable (one pulse per period, spacing >= 4)
//   tx_clk   out  MII TX_CLK toward the MAC (tri-state)
//   tx_en    in   MII TX_EN pin
//   tx_er    in   MII TX_ER pin
//   txd      in   MII TXD pins
//   stb      out  one-cycle pulse: valid/err/data updated this cycle
//   valid    out  sampled TX_EN, gated by jabber/isolate
//   err      out  sampled TX_ER, gated by jabber/isolate
//   data     out  sampled TXD
//   jabber   out  jabber condition active
module mii_io_tx #(
  parameter int JABBER_NIBBLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       isolate,
  input  logic       ce,
  output logic       tx_clk,
  input  logic       tx_en,
  input  logic       tx_er,
  input  logic [3:0] txd,
  output logic       stb,
  output logic       valid,
  output logic       err,
  output logic [3:0] data,
  output logic       jabber
);

  localparam int CNT_W = $clog2(JABBER_NIBBLES + 1);
  localparam logic [CNT_W-1:0] JAB_MAX = CNT_W'(JABBER_NIBBLES);

  typedef enum logic [1:0] {S_HIGH, S_LOW, S_RISING} state_t;

  state_t           state, state_nxt;
  logic             clk_lvl_q;
  logic             clk_oe_q;
  logic             en_p0, er_p0;
  logic [3:0]       txd_p0;
  logic             take;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             jab_nxt;
  logic             stb_p1, vld_p1, err_p1, jab_p1;
  logic [3:0]       data_p1;

  // Saturating increment of the jabber nibble counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= JAB_MAX) ? JAB_MAX : c + CNT_W'(1);
  endfunction

  // TX_CLK phase FSM: a ce pulse always restarts the low phase.
  always_comb begin
    state_nxt = state;
    if (ce) begin
      state_nxt = S_LOW;
    end else begin
      case (state)
        S_LOW:    state_nxt = S_RISING;
        S_RISING: state_nxt = S_HIGH;
        default:  state_nxt = S_HIGH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HIGH;
      clk_lvl_q <= 1'b1;
    end else begin
      state     <= state_nxt;
      clk_lvl_q <= (state_nxt == S_HIGH);
    end
    // Output enable follows isolate one cycle later, including during reset.
    clk_oe_q <= ~isolate;
  end

  assign tx_clk = clk_oe_q ? clk_lvl_q : 1'bz;

  // Stage p0: IO input registers on the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_p0  <= 1'b0;
      er_p0  <= 1'b0;
      txd_p0 <= 4'h0;
    end else begin
      en_p0  <= tx_en;
      er_p0  <= tx_er;
      txd_p0 <= txd;
    end
  end

  // Sample on the last low cycle; a ce landing there truncates the period, so no sample.
  assign take    = (state == S_RISING) && !ce;
  assign cnt_nxt = en_p0 ? sat_inc(cnt_q) : '0;
  assign jab_nxt = en_p0 && (cnt_nxt == JAB_MAX);

  // Stage p1: strobed sample, jabber gating and isolate forcing.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      data_p1 <= 4'h0;
      jab_p1  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      stb_p1 <= take;
      if (isolate) begin
        cnt_q  <= '0;
        jab_p1 <= 1'b0;
        if (take) begin
          vld_p1  <= 1'b0;
          err_p1  <= 1'b0;
          data_p1 <= 4'h0;
        end
      end else if (take) begin
        cnt_q   <= cnt_nxt;
        jab_p1  <= jab_nxt;
        vld_p1  <= en_p0 && !jab_nxt;
        err_p1  <= er_p0 && !jab_nxt;
        data_p1 <= txd_p0;
      end
    end
  end

  assign stb    = stb_p1;
  assign valid  = vld_p1;
  assign err    = err_p1;
  assign data   = data_p1;
  assign jabber = jab_p1;

endmodule

// File: tb/tb_mii_io_tx.sv
module tb_mii_io_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       isolate = 1'b0;
  logic       ce = 1'b0;
  wire        tx_clk;
  logic       tx_en = 1'b0;
  logic       tx_er = 1'b0;
  logic [3:0] txd = 4'h0;
  logic       stb, valid, err, jabber;
  logic [3:0] data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mii_io_tx #(.JABBER_NIBBLES(8)) dut (
    .clk(clk), .rst(rst), .isolate(isolate), .ce(ce), .tx_clk(tx_clk),
    .tx_en(tx_en), .tx_er(tx_er), .txd(txd), .stb(stb), .valid(valid),
    .err(err), .data(data), .jabber(jabber)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic ee,
                          input logic [3:0] ed, input logic ej);
    chk({tag, "_valid"}, {3'b0, valid}, {3'b0, ev});
    chk({tag, "_err"}, {3'b0, err}, {3'b0, ee});
    chk({tag, "_data"}, data, ed);
    chk({tag, "_jabber"}, {3'b0, jabber}, {3'b0, ej});
  endtask

  // One MII period of len clk: ce in the first cycle, pins held for the whole period.
  task automatic run_period(input int len, input logic en, input logic er,
                            input logic [3:0] d, input logic ev, input logic ee,
                            input logic ej, input logic [3:0] ed, input logic iso,
                            input string tag);
    logic ec;
    ce = 1'b1; tx_en = en; tx_er = er; txd = d; isolate = iso;
    for (int i = 1; i <= len; i++) begin
      tick();
      ce = 1'b0;
      if (i < len) begin
        ec = iso ? 1'bz : (i >= 3);
        chk({tag, "_txclk"}, {3'b0, tx_clk}, {3'b0, ec});
        chk({tag, "_stb"}, {3'b0, stb}, {3'b0, (i == 3)});
        if (i == 3) chk_outs(tag, ev, ee, ed, ej);
      end
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_txclk", {3'b0, tx_clk}, 4'h1);
    chk("rst_stb", {3'b0, stb}, 4'h0);
    chk_outs("rst", 1'b0, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    tick(); tick();
    chk("idle_stb", {3'b0, stb}, 4'h0);
    chk("idle_txclk", {3'b0, tx_clk}, 4'h1);

    // 100M periods, constant nibble A
    for (int k = 0; k < 3; k++) run_period(5, 1'b1, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0, "t1");
    run_period(5, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, "t1_idle");

    // Data ramp with a single tx_er nibble; every fourth nibble idle to keep clear of jabber
    for (int k = 0; k < 16; k++) begin
      logic en_k, er_k;
      en_k = (k % 4) != 3;
      er_k = (k == 5);
      run_period(5, en_k, er_k, 4'(k), en_k, er_k, 1'b0, 4'(k), 1'b0, "t2");
    end

    // 10M periods
    run_period(50, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0, "t3a");
    run_period(50, 1'b1, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 4'hC, 1'b0, "t3b");
    run_period(5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "t3_idle");

    // Jabber with JABBER_NIBBLES=8
    for (int k = 0; k < 12; k++) begin
      logic jb, er_k;
      jb = (k >= 7);
      er_k = (k == 2) || (k == 9);
      run_period(5, 1'b1, er_k, 4'(k + 1), !jb, er_k && !jb, jb, 4'(k + 1), 1'b0, "t4");
    end
    run_period(5, 1'b0, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 4'hE, 1'b0, "t4_clear");

    // Isolate mid-frame
    run_period(5, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 4'h4, 1'b0, "t5_pre");
    run_period(5, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "t5_iso");
    run_period(5, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "t5_iso2");
    run_period(5, 1'b1, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 4'h6, 1'b0, "t5_rel");

    // Reset mid-frame
    ce = 1'b1; tx_en = 1'b1; txd = 4'h7;
    tick();
    ce = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_txclk", {3'b0, tx_clk}, 4'h1);
    chk("t6_stb", {3'b0, stb}, 4'h0);
    chk_outs("t6", 1'b0, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_nostb", {3'b0, stb}, 4'h0);
    end

    // ce spaced 2 clk: every period truncated, no strobe
    for (int k = 0; k < 3; k++) begin
      ce = 1'b1;
      tick();
      ce = 1'b0;
      chk("t6_trunc_stb", {3'b0, stb}, 4'h0);
      chk("t6_trunc_clk", {3'b0, tx_clk}, 4'h0);
      tick();
      chk("t6_trunc_stb", {3'b0, stb}, 4'h0);
      chk("t6_trunc_clk", {3'b0, tx_clk}, 4'h0);
    end

    // ce together with rst: reset wins, clock stays high, no strobe
    ce = 1'b1; rst = 1'b1;
    tick();
    ce = 1'b0; rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t6_rstce_clk", {3'b0, tx_clk}, 4'h1);
      chk("t6_rstce_stb", {3'b0, stb}, 4'h0);
      tick();
    end
    run_period(5, 1'b1, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0, 4'h9, 1'b0, "t6_resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
